// File: rtl/chip8_pkg.sv
// Shared types and default memory-map constants for the CHIP-8 ROM loading path.
package chip8_pkg;

    localparam int MEM_DEPTH_DFLT = 4096;
    localparam int LOAD_BASE_DFLT = 'h200;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } load_state_t;

endpackage

// File: rtl/rom_checksum.sv
// Modulo-2^16 running sum of the ROM bytes accepted by rom_stream_loader.
module rom_checksum
    import chip8_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        clear_in,
    input  logic        add_in,
    input  byte_t       data_in,
    output logic [15:0] sum_out
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sum_out <= '0;
        end else if (clear_in) begin
            sum_out <= '0;
        end else if (add_in) begin
            sum_out <= sum_out + {8'h00, data_in};
        end
    end

endmodule

// File: rtl/rom_stream_loader.sv
// Loads a byte-streamed ROM image into memory at LOAD_BASE, optionally zero-filling first.
// Define ROM_CHECKSUM_EN to add checksum_out (16-bit sum of loaded bytes).
module rom_stream_loader
    import chip8_pkg::*;
#(
    parameter int  MEM_DEPTH = MEM_DEPTH_DFLT,
    parameter int  LOAD_BASE = LOAD_BASE_DFLT,
    parameter int  CLEAR_EN  = 1,
    localparam int ADDR_W    = $clog2(MEM_DEPTH),
    localparam int MAX_LEN   = MEM_DEPTH - LOAD_BASE
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic [ADDR_W:0]   rom_len_in,
    input  logic              s_valid_in,
    input  byte_t             s_data_in,
    output logic              s_ready_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output byte_t             mem_wdata_out,
    output logic              busy_out,
    output logic              rom_ready_out,
    output logic              error_out,
    output logic [ADDR_W:0]   bytes_loaded_out
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]       checksum_out
`endif
);

    localparam logic [ADDR_W:0]   MAX_LEN_W = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(MAX_LEN - 1);

    load_state_t       state_q, state_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] clr_q;
    logic              start_ok;
    logic              len_ok;
    logic              xfer;

    assign start_ok = start_in &&
                      (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign len_ok   = (rom_len_in != '0) && (rom_len_in <= MAX_LEN_W);
    assign s_ready_out = (state_q == ST_LOAD) && (count_q < len_q);
    assign xfer        = s_valid_in && s_ready_out;

    assign busy_out         = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign rom_ready_out    = (state_q == ST_DONE);
    assign error_out        = (state_q == ST_ERR);
    assign bytes_loaded_out = count_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_in) begin
                    if (!len_ok) begin
                        state_d = ST_ERR;
                    end else if (CLEAR_EN != 0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = ST_LOAD;
                end
            end
            // Leave LOAD one cycle after the last transfer, once its write is on the port.
            ST_LOAD: begin
                if (count_q == len_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            len_q         <= '0;
            count_q       <= '0;
            clr_q         <= '0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
        end else begin
            mem_we_out <= 1'b0;
            if (start_ok) begin
                len_q   <= rom_len_in;
                count_q <= '0;
                clr_q   <= '0;
            end else if (state_q == ST_CLEAR) begin
                mem_we_out    <= 1'b1;
                mem_addr_out  <= BASE_A + clr_q;
                mem_wdata_out <= '0;
                clr_q         <= clr_q + 1'b1;
            end else if (xfer) begin
                // count_q < len_q <= MAX_LEN, so the sum stays below MEM_DEPTH.
                mem_we_out    <= 1'b1;
                mem_addr_out  <= BASE_A + count_q[ADDR_W-1:0];
                mem_wdata_out <= s_data_in;
                count_q       <= count_q + 1'b1;
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    rom_checksum u_checksum (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear_in (start_ok),
        .add_in   (xfer),
        .data_in  (s_data_in),
        .sum_out  (checksum_out)
    );
`endif

endmodule

// File: tb/tb_rom_stream_loader.sv
// Self-checking bench for rom_stream_loader: one instance without and one with the zero-fill pass.
module tb_rom_stream_loader;
    import chip8_pkg::*;

    localparam int BASE = 'h200;
    localparam int MAXL = 4096 - 'h200;

    typedef struct {int cyc; int addr; int data; bit busy;} wr_t;
    typedef struct {int cyc; int data;} xf_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [12:0] len0 = '0, len1 = '0;
    logic        v0 = 1'b0, v1 = 1'b0;
    byte_t       d0 = '0, d1 = '0;
    logic        r0, r1, we0, we1, busy0, busy1, rdy0, rdy1, err0, err1;
    logic [11:0] a0, a1;
    byte_t       wd0, wd1;
    logic [12:0] bl0, bl1;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] cs0, cs1;
`endif

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    wr_t   wr0[$], wr1[$];
    xf_t   xf0[$];
    byte_t stim[$];
    byte_t stim1[$];

    always #5 clk = ~clk;

    rom_stream_loader #(.CLEAR_EN(0)) dut0 (
        .clk_in(clk), .rst_n(rst_n), .start_in(start0), .rom_len_in(len0),
        .s_valid_in(v0), .s_data_in(d0), .s_ready_out(r0),
        .mem_we_out(we0), .mem_addr_out(a0), .mem_wdata_out(wd0),
        .busy_out(busy0), .rom_ready_out(rdy0), .error_out(err0), .bytes_loaded_out(bl0)
`ifdef ROM_CHECKSUM_EN
        , .checksum_out(cs0)
`endif
    );

    rom_stream_loader #(.CLEAR_EN(1)) dut1 (
        .clk_in(clk), .rst_n(rst_n), .start_in(start1), .rom_len_in(len1),
        .s_valid_in(v1), .s_data_in(d1), .s_ready_out(r1),
        .mem_we_out(we1), .mem_addr_out(a1), .mem_wdata_out(wd1),
        .busy_out(busy1), .rom_ready_out(rdy1), .error_out(err1), .bytes_loaded_out(bl1)
`ifdef ROM_CHECKSUM_EN
        , .checksum_out(cs1)
`endif
    );

    // Transfers are logged with the cycle in which their write must appear.
    always @(posedge clk) begin
        if (rst_n && v0 && r0) xf0.push_back('{cyc + 1, int'(d0)});
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (we0) wr0.push_back('{cyc, int'(a0), int'(wd0), busy0});
        if (we1) wr1.push_back('{cyc, int'(a1), int'(wd1), busy1});
    end

    function automatic logic [15:0] model_sum(input byte_t q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return 16'(s);
    endfunction

    function automatic int first_bad(input byte_t q[$]);
        foreach (wr0[k]) begin
            if (k >= q.size() || k >= xf0.size() || wr0[k].addr != BASE + k ||
                wr0[k].data != int'(q[k]) || wr0[k].cyc != xf0[k].cyc) return k;
        end
        return -1;
    endfunction

    task automatic fill_rand(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(byte_t'($urandom_range(0, 255)));
    endtask

    task automatic do_start0(input int len);
        @(posedge clk); #1;
        start0 = 1'b1;
        len0   = 13'(len);
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    // mode 0: always valid, 1: valid pattern 1,0,0 repeating, 2: random valid
    task automatic stream0(input int mode, input int max_cyc, output int taken);
        int n = 0;
        bit v, r;
        taken = 0;
        while (taken < stim.size() && n < max_cyc) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            v0 = v;
            d0 = stim[taken];
            @(negedge clk);
            r = r0;
            @(posedge clk); #1;
            if (v && r) taken++;
            n++;
        end
        v0 = 1'b0;
    endtask

    task automatic wait_done0(input string tag, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (rdy0 || err0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout rom_ready never rose within %0d cycles", tag, max_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({r0, we0, a0, wd0, busy0, rdy0, err0, bl0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0 outputs=%h required=0", {r0, we0, a0, wd0, busy0, rdy0, err0, bl0});
        end
        checks++;
        if ({r1, we1, a1, wd1, busy1, rdy1, err1, bl1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 outputs=%h required=0", {r1, we1, a1, wd1, busy1, rdy1, err1, bl1});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, rdy0, err0, bl0, we0} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h required=0", {busy0, rdy0, err0, bl0, we0});
        end
    endtask

    task automatic test_back_to_back();
        int taken, bad;
        stim = '{8'h12, 8'h34, 8'h56, 8'h78};
        wr0.delete(); xf0.delete();
        do_start0(4);
        stream0(0, 50, taken);
        wait_done0("b2b", 20);
        bad = first_bad(stim);
        checks++;
        if (wr0.size() != 4 || xf0.size() != 4 || bad >= 0) begin
            errors++;
            $display("FAIL b2b_writes got=%0d writes (first bad %0d) required=4 in order", wr0.size(), bad);
        end
        checks++;
        if (xf0.size() == 4 && xf0[3].cyc != xf0[0].cyc + 3) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d cycles required=3", xf0[3].cyc - xf0[0].cyc);
        end
        checks++;
        if ({rdy0, busy0, err0, r0} !== 4'b1000 || bl0 !== 13'd4) begin
            errors++;
            $display("FAIL b2b_status rdy/busy/err/rdy_s=%b loaded=%0d required=1000 and 4", {rdy0, busy0, err0, r0}, bl0);
        end
`ifdef ROM_CHECKSUM_EN
        checks++;
        if (cs0 !== 16'h0114) begin
            errors++;
            $display("FAIL b2b_checksum got=%h required=0114", cs0);
        end
`endif
        // Largest legal image: last byte lands at MEM_DEPTH-1.
        fill_rand(MAXL);
        wr0.delete(); xf0.delete();
        do_start0(MAXL);
        stream0(0, MAXL + 50, taken);
        wait_done0("maxlen", 20);
        bad = first_bad(stim);
        checks++;
        if (wr0.size() != MAXL || bad >= 0 || wr0[wr0.size() - 1].addr != 'hFFF) begin
            errors++;
            $display("FAIL maxlen_writes got=%0d (first bad %0d) required=%0d ending at fff", wr0.size(), bad, MAXL);
        end
        checks++;
        if (rdy0 !== 1'b1 || bl0 !== 13'(MAXL)) begin
            errors++;
            $display("FAIL maxlen_status rdy=%b loaded=%0d required=1 and %0d", rdy0, bl0, MAXL);
        end
`ifdef ROM_CHECKSUM_EN
        checks++;
        if (cs0 !== model_sum(stim)) begin
            errors++;
            $display("FAIL maxlen_checksum got=%h required=%h", cs0, model_sum(stim));
        end
`endif
    endtask

    task automatic test_stalls();
        int taken, bad, n;
        for (int run = 0; run < 4; run++) begin
            if (run == 0) stim = '{8'h12, 8'h34, 8'h56, 8'h78};
            else fill_rand($urandom_range(1, 64));
            n = stim.size();
            wr0.delete(); xf0.delete();
            do_start0(n);
            stream0(run == 0 ? 1 : 2, 2000, taken);
            wait_done0("stall", 20);
            bad = first_bad(stim);
            checks++;
            if (wr0.size() != n || xf0.size() != n || bad >= 0) begin
                errors++;
                $display("FAIL stall_writes run=%0d got=%0d (first bad %0d) required=%0d", run, wr0.size(), bad, n);
            end
            checks++;
            if (rdy0 !== 1'b1 || bl0 !== 13'(n)) begin
                errors++;
                $display("FAIL stall_status run=%0d rdy=%b loaded=%0d required=1 and %0d", run, rdy0, bl0, n);
            end
`ifdef ROM_CHECKSUM_EN
            checks++;
            if (cs0 !== model_sum(stim)) begin
                errors++;
                $display("FAIL stall_checksum run=%0d got=%h required=%h", run, cs0, model_sum(stim));
            end
`endif
        end
    endtask

    task automatic test_len_errors();
        int taken, bad;
        int bad_lens[2] = '{0, MAXL + 1};
        foreach (bad_lens[i]) begin
            wr0.delete(); xf0.delete();
            v0 = 1'b1;
            d0 = byte_t'($urandom_range(0, 255));
            do_start0(bad_lens[i]);
            repeat (4) @(negedge clk);
            checks++;
            if ({err0, rdy0, busy0, r0} !== 4'b1000 || bl0 !== '0 || wr0.size() != 0 || xf0.size() != 0) begin
                errors++;
                $display("FAIL len_err len=%0d err/rdy/busy/rdy_s=%b loaded=%0d writes=%0d required=1000,0,0",
                         bad_lens[i], {err0, rdy0, busy0, r0}, bl0, wr0.size());
            end
`ifdef ROM_CHECKSUM_EN
            checks++;
            if (cs0 !== 16'h0) begin
                errors++;
                $display("FAIL len_err_checksum got=%h required=0000", cs0);
            end
`endif
            v0 = 1'b0;
        end
        fill_rand(2);
        wr0.delete(); xf0.delete();
        do_start0(2);
        stream0(0, 20, taken);
        wait_done0("recover", 20);
        bad = first_bad(stim);
        checks++;
        if (wr0.size() != 2 || bad >= 0 || {rdy0, err0} !== 2'b10) begin
            errors++;
            $display("FAIL len_recover writes=%0d bad=%0d rdy/err=%b required=2,-1,10", wr0.size(), bad, {rdy0, err0});
        end
    endtask

    task automatic test_reset_mid_load();
        int taken, bad;
        byte_t b3;
        fill_rand(2);
        b3 = byte_t'($urandom_range(0, 255));
        wr0.delete(); xf0.delete();
        do_start0(4);
        stream0(0, 20, taken);
        v0 = 1'b1;
        d0 = b3;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r0, we0, a0, wd0, busy0, rdy0, err0, bl0} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h required=0", {r0, we0, a0, wd0, busy0, rdy0, err0, bl0});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (xf0.size() != 2 || wr0.size() != 2 || first_bad(stim) >= 0 || {busy0, r0, bl0} !== '0) begin
            errors++;
            $display("FAIL midreset_abandon xfers=%0d writes=%0d busy=%b loaded=%0d required=2,2,0,0",
                     xf0.size(), wr0.size(), busy0, bl0);
        end
        v0 = 1'b0;
        fill_rand(4);
        wr0.delete(); xf0.delete();
        do_start0(4);
        stream0(2, 200, taken);
        wait_done0("restart", 20);
        bad = first_bad(stim);
        checks++;
        if (wr0.size() != 4 || bad >= 0 || rdy0 !== 1'b1 || bl0 !== 13'd4) begin
            errors++;
            $display("FAIL midreset_restart writes=%0d bad=%0d rdy=%b loaded=%0d required=4,-1,1,4",
                     wr0.size(), bad, rdy0, bl0);
        end
    endtask

    task automatic test_ignore();
        int taken, bad;
        byte_t full[$];
        fill_rand(2);
        wr0.delete(); xf0.delete();
        do_start0(1);
        stream0(0, 10, taken);
        checks++;
        if (xf0.size() != 1 || wr0.size() != 1 || first_bad(stim) >= 0 || bl0 !== 13'd1 ||
            {rdy0, r0} !== 2'b10) begin
            errors++;
            $display("FAIL len1_extra xfers=%0d writes=%0d loaded=%0d rdy/rdy_s=%b required=1,1,1,10",
                     xf0.size(), wr0.size(), bl0, {rdy0, r0});
        end
        fill_rand(3);
        full = stim;
        wr0.delete(); xf0.delete();
        do_start0(3);
        stim = '{full[0]};
        stream0(0, 10, taken);
        start0 = 1'b1;
        len0   = 13'd1;
        @(posedge clk); #1;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || bl0 !== 13'd1) begin
            errors++;
            $display("FAIL start_in_load busy=%b loaded=%0d required=1 and 1", busy0, bl0);
        end
        stim = '{full[1], full[2]};
        stream0(0, 10, taken);
        wait_done0("ignore", 20);
        bad = first_bad(full);
        checks++;
        if (wr0.size() != 3 || bad >= 0 || bl0 !== 13'd3 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored writes=%0d bad=%0d loaded=%0d rdy=%b required=3,-1,3,1",
                     wr0.size(), bad, bl0, rdy0);
        end
    endtask

    task automatic test_clear();
        int taken = 0, gaps = 0, bad = -1;
        bit done = 1'b0, v, r;
        stim1.delete();
        for (int i = 0; i < 2; i++) stim1.push_back(byte_t'($urandom_range(1, 255)));
        wr1.delete();
        @(posedge clk); #1;
        start1 = 1'b1;
        len1   = 13'd2;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int n = 0; n < MAXL + 100 && !done; n++) begin
            v  = (taken < 2);
            v1 = v;
            d1 = v ? stim1[taken] : 8'h00;
            @(negedge clk);
            r = r1;
            if (rdy1) done = 1'b1;
            else if (!busy1) gaps++;
            @(posedge clk); #1;
            if (v && r) taken++;
        end
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL clear_timeout rom_ready never rose");
        end
        foreach (wr1[k]) begin
            if (bad < 0 && (wr1[k].addr != BASE + (k < MAXL ? k : k - MAXL) || !wr1[k].busy ||
                wr1[k].data != (k < MAXL ? 0 : (k - MAXL < 2 ? int'(stim1[k - MAXL]) : -1))))
                bad = k;
        end
        checks++;
        if (wr1.size() != MAXL + 2 || bad >= 0) begin
            errors++;
            $display("FAIL clear_writes got=%0d (first bad %0d) required=%0d", wr1.size(), bad, MAXL + 2);
        end
        checks++;
        if (gaps != 0 || bl1 !== 13'd2 || {rdy1, busy1, err1} !== 3'b100) begin
            errors++;
            $display("FAIL clear_status busy_gaps=%0d loaded=%0d rdy/busy/err=%b required=0,2,100",
                     gaps, bl1, {rdy1, busy1, err1});
        end
`ifdef ROM_CHECKSUM_EN
        checks++;
        if (cs1 !== model_sum(stim1)) begin
            errors++;
            $display("FAIL clear_checksum got=%h required=%h", cs1, model_sum(stim1));
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stalls();
        test_len_errors();
        test_reset_mid_load();
        test_ignore();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
